instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Converts mnemonic-level requests (mnemonic ID, register fields, immediate/target) into 32-bit MIPS machine words for the P4 subset, and tags each word with its instruction-memory address.
- The inverse of the controller's decode; feeds the IM preload path and the self-checking test harness.
- Expands the `li` pseudo-instruction to one or two words.
- Detects unencodable requests.
- Valid/ready handshake on both sides, with a single registered output stage.

Parameters:
- PC_BASE, 32'h0000_3000, address assigned to the first emitted word after reset.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  encoder accepts request this cycle
- req_mnem  in  5  mnemonic ID: 0 nop, 1 addu, 2 subu, 3 and, 4 slt, 5 sll, 6 jr, 7 ori, 8 addiu, 9 lui, 10 lw, 11 sw, 12 lb, 13 sb, 14 beq, 15 blez, 16 j, 17 jal, 18 li; 19-31 illegal
- req_rs  in  5  rs field (base register for loads/stores)
- req_rt  in  5  rt field (destination for I-type and li)
- req_rd  in  5  rd field
- req_shamt  in  5  shift amount (sll)
- req_imm  in  32  immediate: low 16 bits for I-type; byte target address for beq/blez/j/jal; full value for li
- out_valid  out  1  encoded word held
- out_ready  in  1  consumer takes word
- out_instr  out  32  machine word
- out_addr  out  32  address of out_instr
- err  out  1  one-cycle pulse: accepted request was unencodable
- err_code  out  2  1 illegal mnemonic, 2 branch misaligned/out of range, 3 jump misaligned/out of region; valid while err=1

Behaviour:
- Reset values:
  - out_valid=0, out_instr=0, out_addr=0
  - err=0, err_code=0
  - next_addr=PC_BASE
  - state=IDLE
- Reset mid-`li` discards the pending low half.
- States:
  - IDLE: req_ready = !out_valid || out_ready.
  - LI_LO: req_ready=0.
- Accept condition: req_valid && req_ready, evaluated at the clock edge. Encoding is combinational from req_* and next_addr; the result is registered, so out_valid rises the cycle after acceptance (latency 1).
- Output register:
  - Loaded with out_instr=word and out_addr=next_addr; next_addr += 4 in the same edge.
  - Holds stable while out_valid && !out_ready.
  - out_valid clears on out_valid && out_ready when no new word is loaded in that edge.
  - A simultaneous consume and load is a back-to-back transfer with no bubble.
- Field formats:
  - R-type = {6'h00, rs, rt, rd, shamt, func}. Funcs: addu 21, subu 23, and 24, slt 2A, sll 00, jr 08 (hex).
  - For sll, rs=0. For jr, rt=rd=shamt=0.
  - I-type = {op, rs, rt, imm[15:0]}. Ops: ori 0D, addiu 09, lui 0F (rs=0), lw 23, sw 2B, lb 20, sb 28, beq 04, blez 06 (rt=0).
  - nop = 32'h0.
- beq/blez offset:
  - diff = req_imm - (next_addr+4), 32-bit two's complement.
  - err_code 2 if diff[1:0]!=0 or diff outside [-131072, 131068].
  - Otherwise imm16 = diff[17:2].
- j/jal:
  - {op 02/03, req_imm[27:2]}.
  - err_code 3 if req_imm[1:0]!=0 or req_imm[31:28] != (next_addr+4)[31:28].
- li:
  - If req_imm[31:16]==0: single word `ori rt,$0,imm[15:0]`; stay in IDLE.
  - Else: emit `lui rt,imm[31:16]`, latch rt and imm[15:0], go to LI_LO.
  - In LI_LO, on out_valid && out_ready, load `ori rt,rt,imm_lo` at next_addr, return to IDLE.
  - The two words are always at consecutive addresses.
- Errors:
  - An accepted bad request pulses err with err_code for exactly one cycle.
  - The output register, next_addr and state are untouched by an error.
  - A pending output word still drains normally.
- Unused request fields are ignored, not checked.

Test Plan:
- Reset, then addu rs=1 rt=2 rd=3 with out_ready=1 -> out_instr=0x00221821, out_addr=0x3000, out_valid high exactly 1 cycle after acceptance.
- li rt=8 imm=0x12345678 -> 0x3C081234 @0x3000, then 0x35085678 @0x3004; req_ready=0 until the second word is loaded. li rt=8 imm=0x0000ABCD -> single 0x3408ABCD.
- Three nops, then beq rs=1 rt=2 target 0x3000 -> word @0x300C = 0x1022FFFC. Separately, jal target 0x3010 -> 0x0C000C04.
- lw rs=29 rt=4 imm=0xFFFFFFFC -> 0x8FA4FFFC. beq target 0x3002 -> err=1, err_code=2 for one cycle, no word emitted, next request still gets the expected address.
- Hold out_ready=0 for 3 cycles with a word pending -> out_instr/out_addr stable, req_ready=0; then out_ready=1 with a new request pending -> back-to-back transfer, no bubble.
- Assert reset in LI_LO -> out_valid=0 next cycle, low half never emitted, next word at 0x3000; mnem=25 -> err_code=1.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: turns mnemonic-level requests into 32-bit MIPS words for the P4 subset,
// tagging each word with its instruction-memory address. Expands li into one or two words,
// flags unencodable requests, and has a single registered output stage with valid/ready.
module instr_encoder #(
  parameter logic [31:0] PC_BASE = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_mnem,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_shamt,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_LI_LO = 1'b1;

  localparam logic [4:0] M_NOP   = 5'd0;
  localparam logic [4:0] M_ADDU  = 5'd1;
  localparam logic [4:0] M_SUBU  = 5'd2;
  localparam logic [4:0] M_AND   = 5'd3;
  localparam logic [4:0] M_SLT   = 5'd4;
  localparam logic [4:0] M_SLL   = 5'd5;
  localparam logic [4:0] M_JR    = 5'd6;
  localparam logic [4:0] M_ORI   = 5'd7;
  localparam logic [4:0] M_ADDIU = 5'd8;
  localparam logic [4:0] M_LUI   = 5'd9;
  localparam logic [4:0] M_LW    = 5'd10;
  localparam logic [4:0] M_SW    = 5'd11;
  localparam logic [4:0] M_LB    = 5'd12;
  localparam logic [4:0] M_SB    = 5'd13;
  localparam logic [4:0] M_BEQ   = 5'd14;
  localparam logic [4:0] M_BLEZ  = 5'd15;
  localparam logic [4:0] M_J     = 5'd16;
  localparam logic [4:0] M_JAL   = 5'd17;
  localparam logic [4:0] M_LI    = 5'd18;

  localparam logic [1:0] E_ILLEGAL = 2'd1;
  localparam logic [1:0] E_BRANCH  = 2'd2;
  localparam logic [1:0] E_JUMP    = 2'd3;

  logic        r_state;
  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic [31:0] r_out_addr;
  logic [31:0] r_next_addr;
  logic        r_err;
  logic [1:0]  r_err_code;
  logic [4:0]  r_li_rt;
  logic [15:0] r_li_lo;

  logic [31:0] w_pc4;
  logic [31:0] w_br_diff;
  logic        w_br_bad;
  logic        w_j_bad;
  logic [31:0] w_word;
  logic        w_bad;
  logic [1:0]  w_code;
  logic        w_li_two;
  logic        w_accept;
  logic        w_good;
  logic        w_li_lo_load;
  logic        w_load;
  logic [31:0] w_load_word;

  assign w_pc4     = r_next_addr + 32'd4;
  assign w_br_diff = req_imm - w_pc4;
  // In range iff diff is a sign-extended 18-bit value: bits [31:17] all equal.
  assign w_br_bad  = (w_br_diff[1:0] != 2'b00) ||
                     !((w_br_diff[31:17] == 15'h0000) || (w_br_diff[31:17] == 15'h7fff));
  assign w_j_bad   = (req_imm[1:0] != 2'b00) || (req_imm[31:28] != w_pc4[31:28]);

  // Combinational encode of the incoming request.
  always_comb begin
    w_word   = 32'h0;
    w_bad    = 1'b0;
    w_code   = 2'd0;
    w_li_two = 1'b0;
    case (req_mnem)
      M_NOP:   w_word = 32'h0;
      M_ADDU:  w_word = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h21};
      M_SUBU:  w_word = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h23};
      M_AND:   w_word = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h24};
      M_SLT:   w_word = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h2A};
      M_SLL:   w_word = {6'h00, 5'd0, req_rt, req_rd, req_shamt, 6'h00};
      M_JR:    w_word = {6'h00, req_rs, 15'd0, 6'h08};
      M_ORI:   w_word = {6'h0D, req_rs, req_rt, req_imm[15:0]};
      M_ADDIU: w_word = {6'h09, req_rs, req_rt, req_imm[15:0]};
      M_LUI:   w_word = {6'h0F, 5'd0, req_rt, req_imm[15:0]};
      M_LW:    w_word = {6'h23, req_rs, req_rt, req_imm[15:0]};
      M_SW:    w_word = {6'h2B, req_rs, req_rt, req_imm[15:0]};
      M_LB:    w_word = {6'h20, req_rs, req_rt, req_imm[15:0]};
      M_SB:    w_word = {6'h28, req_rs, req_rt, req_imm[15:0]};
      M_BEQ: begin
        w_word = {6'h04, req_rs, req_rt, w_br_diff[17:2]};
        w_bad  = w_br_bad;
        w_code = E_BRANCH;
      end
      M_BLEZ: begin
        w_word = {6'h06, req_rs, 5'd0, w_br_diff[17:2]};
        w_bad  = w_br_bad;
        w_code = E_BRANCH;
      end
      M_J: begin
        w_word = {6'h02, req_imm[27:2]};
        w_bad  = w_j_bad;
        w_code = E_JUMP;
      end
      M_JAL: begin
        w_word = {6'h03, req_imm[27:2]};
        w_bad  = w_j_bad;
        w_code = E_JUMP;
      end
      M_LI: begin
        if (req_imm[31:16] == 16'h0000) begin
          w_word = {6'h0D, 5'd0, req_rt, req_imm[15:0]};
        end else begin
          w_word   = {6'h0F, 5'd0, req_rt, req_imm[31:16]};
          w_li_two = 1'b1;
        end
      end
      default: begin
        w_bad  = 1'b1;
        w_code = E_ILLEGAL;
      end
    endcase
  end

  assign req_ready    = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_accept     = req_valid && req_ready;
  assign w_good       = w_accept && !w_bad;
  // The lui half is always the word pending in LI_LO, so its consumption loads the ori half.
  assign w_li_lo_load = (r_state == ST_LI_LO) && r_out_valid && out_ready;
  assign w_load       = w_good || w_li_lo_load;
  assign w_load_word  = w_li_lo_load ? {6'h0D, r_li_rt, r_li_rt, r_li_lo} : w_word;

  // Output register and address counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_instr <= 32'h0;
      r_out_addr  <= 32'h0;
      r_next_addr <= PC_BASE;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_instr <= w_load_word;
      r_out_addr  <= r_next_addr;
      r_next_addr <= r_next_addr + 32'd4;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // li sequencing: latch the low half and wait for the lui word to drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_li_rt <= 5'd0;
      r_li_lo <= 16'h0;
    end else if (w_good && w_li_two) begin
      r_state <= ST_LI_LO;
      r_li_rt <= req_rt;
      r_li_lo <= req_imm[15:0];
    end else if (w_li_lo_load) begin
      r_state <= ST_IDLE;
    end
  end

  // One-cycle error pulse for an accepted unencodable request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
    end else begin
      r_err      <= w_accept && w_bad;
      r_err_code <= (w_accept && w_bad) ? w_code : 2'd0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_addr  = r_out_addr;
  assign err       = r_err;
  assign err_code  = r_err_code;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed machine words and addresses.
module tb_instr_encoder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_mnem;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic [4:0]  req_shamt;
  logic [31:0] req_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic [1:0]  err_code;

  int checks;
  int failures;

  instr_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mnem  (req_mnem),
    .req_rs    (req_rs),
    .req_rt    (req_rt),
    .req_rd    (req_rd),
    .req_shamt (req_shamt),
    .req_imm   (req_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err),
    .err_code  (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Present a request and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic do_req(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [31:0] imm);
    bit done;
    req_mnem  = m;
    req_rs    = rs;
    req_rt    = rt;
    req_rd    = rd;
    req_shamt = sh;
    req_imm   = imm;
    req_valid = 1'b1;
    done      = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (req_ready) done = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL accept_timeout mnem=%0d: req_ready never rose, required within 20 cycles", m);
    end
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b want=0", out_valid);
    end
    checks++;
    if (out_instr !== 32'h0 || out_addr !== 32'h0) begin
      failures++; $display("FAIL reset_out got=%h@%h want=0@0", out_instr, out_addr);
    end
    checks++;
    if (err !== 1'b0 || err_code !== 2'd0) begin
      failures++; $display("FAIL reset_err got=%b/%0d want=0/0", err, err_code);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b want=1", req_ready);
    end
  endtask

  task automatic test_addu();
    do_reset();
    out_ready = 1'b1;
    do_req(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00221821 || out_addr !== 32'h3000) begin
      failures++;
      $display("FAIL addu got=%b %h@%h want=1 00221821@00003000", out_valid, out_instr, out_addr);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL addu_one_cycle got=%b want=0", out_valid);
    end
  endtask

  task automatic test_li();
    do_reset();
    out_ready = 1'b0;
    do_req(5'd18, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12345678);
    checks++;
    if (out_instr !== 32'h3C081234 || out_addr !== 32'h3000 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL li_hi got=%h@%h rdy=%b want=3c081234@00003000 rdy=0",
               out_instr, out_addr, req_ready);
    end
    out_ready = 1'b1;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++; $display("FAIL li_lo_ready got=%b want=0", req_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h35085678 || out_addr !== 32'h3004) begin
      failures++;
      $display("FAIL li_lo got=%b %h@%h want=1 35085678@00003004", out_valid, out_instr, out_addr);
    end
    do_req(5'd18, 5'd0, 5'd8, 5'd0, 5'd0, 32'h0000ABCD);
    checks++;
    if (out_instr !== 32'h3408ABCD || out_addr !== 32'h3008) begin
      failures++; $display("FAIL li_short got=%h@%h want=3408abcd@00003008", out_instr, out_addr);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL li_short_single got=%b want=0", out_valid);
    end
  endtask

  task automatic test_branch_jump();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_req(5'd0, 5'd7, 5'd7, 5'd7, 5'd7, 32'hFFFF_FFFF);
      checks++;
      if (out_instr !== 32'h0 || out_addr !== 32'h3000 + 32'(4 * k)) begin
        failures++; $display("FAIL nop%0d got=%h@%h want=0@%h", k, out_instr, out_addr,
                             32'h3000 + 32'(4 * k));
      end
    end
    do_req(5'd14, 5'd1, 5'd2, 5'd0, 5'd0, 32'h3000);
    checks++;
    if (out_instr !== 32'h1022FFFC || out_addr !== 32'h300C) begin
      failures++; $display("FAIL beq got=%h@%h want=1022fffc@0000300c", out_instr, out_addr);
    end
    do_req(5'd5, 5'd9, 5'd3, 5'd2, 5'd4, 32'h0);
    checks++;
    if (out_instr !== 32'h00031100 || out_addr !== 32'h3010) begin
      failures++; $display("FAIL sll got=%h@%h want=00031100@00003010", out_instr, out_addr);
    end
    do_reset();
    do_req(5'd17, 5'd0, 5'd0, 5'd0, 5'd0, 32'h3010);
    checks++;
    if (out_instr !== 32'h0C000C04 || out_addr !== 32'h3000) begin
      failures++; $display("FAIL jal got=%h@%h want=0c000c04@00003000", out_instr, out_addr);
    end
  endtask

  task automatic test_error();
    do_reset();
    out_ready = 1'b1;
    do_req(5'd10, 5'd29, 5'd4, 5'd0, 5'd0, 32'hFFFFFFFC);
    checks++;
    if (out_instr !== 32'h8FA4FFFC || out_addr !== 32'h3000) begin
      failures++; $display("FAIL lw got=%h@%h want=8fa4fffc@00003000", out_instr, out_addr);
    end
    do_req(5'd14, 5'd1, 5'd2, 5'd0, 5'd0, 32'h3002);
    checks++;
    if (err !== 1'b1 || err_code !== 2'd2 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL beq_misaligned got err=%b code=%0d vld=%b want 1/2/0", err, err_code, out_valid);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL err_pulse got=%b want=0", err);
    end
    do_req(5'd16, 5'd0, 5'd0, 5'd0, 5'd0, 32'h1000_3000);
    checks++;
    if (err !== 1'b1 || err_code !== 2'd3) begin
      failures++; $display("FAIL j_region got err=%b code=%0d want 1/3", err, err_code);
    end
    do_req(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
    checks++;
    if (out_instr !== 32'h00221821 || out_addr !== 32'h3004 || err !== 1'b0) begin
      failures++;
      $display("FAIL after_err got=%h@%h err=%b want=00221821@00003004 err=0",
               out_instr, out_addr, err);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    do_req(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h00221821 || out_addr !== 32'h3000 ||
          req_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold%0d got=%b %h@%h rdy=%b want=1 00221821@00003000 rdy=0",
                 k, out_valid, out_instr, out_addr, req_ready);
      end
    end
    out_ready = 1'b1;
    do_req(5'd2, 5'd4, 5'd5, 5'd6, 5'd0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00853023 || out_addr !== 32'h3004) begin
      failures++;
      $display("FAIL b2b got=%b %h@%h want=1 00853023@00003004", out_valid, out_instr, out_addr);
    end
  endtask

  task automatic test_reset_li();
    do_reset();
    out_ready = 1'b0;
    do_req(5'd18, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12345678);
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_li_valid got=%b want=0", out_valid);
    end
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_li_no_lo got vld=%b rdy=%b want 0/1", out_valid, req_ready);
    end
    do_req(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
    checks++;
    if (out_addr !== 32'h3000) begin
      failures++; $display("FAIL reset_li_addr got=%h want=00003000", out_addr);
    end
    do_req(5'd25, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    checks++;
    if (err !== 1'b1 || err_code !== 2'd1) begin
      failures++; $display("FAIL illegal got err=%b code=%0d want 1/1", err, err_code);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_mnem  = 5'd0;
    req_rs    = 5'd0;
    req_rt    = 5'd0;
    req_rd    = 5'd0;
    req_shamt = 5'd0;
    req_imm   = 32'h0;
    out_ready = 1'b1;
    test_reset();
    test_addu();
    test_li();
    test_branch_jump();
    test_error();
    test_back_to_back();
    test_reset_li();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
